// File: rtl/req_debounce_latch_if.sv
// Request front-end bus: raw request lines and acknowledge in,
// debounced levels, sticky pending/overrun vectors and ack error out.
interface req_debounce_latch_if;
    logic [3:0] raw_in;
    logic       ack;
    logic [1:0] ack_idx;
    logic       clr_overrun;
    logic [3:0] pending;
    logic       any_pending;
    logic [3:0] clean;
    logic [3:0] overrun;
    logic       ack_err;

    // Driver side: supplies requests and acknowledges, observes state.
    modport master (
        output raw_in,
        output ack,
        output ack_idx,
        output clr_overrun,
        input  pending,
        input  any_pending,
        input  clean,
        input  overrun,
        input  ack_err
    );

    // Block side: consumes requests and acknowledges, presents state.
    modport slave (
        input  raw_in,
        input  ack,
        input  ack_idx,
        input  clr_overrun,
        output pending,
        output any_pending,
        output clean,
        output overrun,
        output ack_err
    );
endinterface

// File: rtl/req_debounce_latch.sv
// Four-channel request front-end for the 4-to-2 priority encoder.
// Each raw line is double-flop synchronized, debounced with its own
// counter, and every debounced rising edge becomes a sticky pending bit.
// Pending bits are retired by an acknowledge carrying the encoded index.
// Presses landing on an already pending bit raise a sticky overrun flag.
module req_debounce_latch #(
    parameter int unsigned DB_CYCLES = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    req_debounce_latch_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 32'd1);

    // One-hot decode of the acknowledged index.
    function automatic logic [3:0] idx_onehot(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    // Registered state
    logic [3:0]       sync1_r;
    logic [3:0]       sync2_r;
    logic [3:0]       clean_r;
    logic [CNT_W-1:0] cnt_r [4];
    logic [3:0]       pending_r;
    logic [3:0]       overrun_r;
    logic             ack_err_r;

    // Next-state / decode
    logic [CNT_W-1:0] cnt_nxt_s [4];
    logic [3:0]       clean_nxt_s;
    logic [3:0]       press_s;
    logic [3:0]       ack_hit_s;
    logic [3:0]       pending_nxt_s;
    logic [3:0]       ovr_set_s;
    logic [3:0]       overrun_nxt_s;
    logic             ack_err_nxt_s;

    // Two-flop synchronizer per request line; only the second stage is used.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 4'b0000;
            sync2_r <= 4'b0000;
        end else begin
            sync1_r <= bus.raw_in;
            sync2_r <= sync1_r;
        end
    end

    // Debounce: count consecutive cycles of disagreement, toggle on the last one.
    always_comb begin
        clean_nxt_s = clean_r;
        press_s     = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            cnt_nxt_s[i] = CNT_ZERO;
            if (sync2_r[i] == clean_r[i]) begin
                cnt_nxt_s[i] = CNT_ZERO;
            end else if (cnt_r[i] == CNT_LAST) begin
                cnt_nxt_s[i]   = CNT_ZERO;
                clean_nxt_s[i] = sync2_r[i];
                // Only a 0->1 toggle is a press; releases produce no event.
                press_s[i]     = sync2_r[i];
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
            end
        end
    end

    // Debounced level and per-bit counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            clean_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            clean_r <= clean_nxt_s;
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Acknowledge decode: which bit, if any, the current strobe targets.
    always_comb begin
        if (bus.ack) begin
            ack_hit_s = idx_onehot(bus.ack_idx);
        end else begin
            ack_hit_s = 4'b0000;
        end
    end

    // Pending/overrun next state: a press always wins over a same-cycle ack.
    always_comb begin
        pending_nxt_s = pending_r;
        ovr_set_s     = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (press_s[i]) begin
                pending_nxt_s[i] = 1'b1;
                ovr_set_s[i]     = pending_r[i] & ~ack_hit_s[i];
            end else if (ack_hit_s[i] && pending_r[i]) begin
                pending_nxt_s[i] = 1'b0;
            end else begin
                pending_nxt_s[i] = pending_r[i];
            end
        end
        // A fresh overrun survives a simultaneous clear.
        if (bus.clr_overrun) begin
            overrun_nxt_s = ovr_set_s;
        end else begin
            overrun_nxt_s = overrun_r | ovr_set_s;
        end
    end

    // Ack error: strobe aimed at a bit that is not currently pending.
    always_comb begin
        if (bus.ack) begin
            ack_err_nxt_s = ~pending_r[bus.ack_idx];
        end else begin
            ack_err_nxt_s = 1'b0;
        end
    end

    // Registered request state and error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_r <= 4'b0000;
            overrun_r <= 4'b0000;
            ack_err_r <= 1'b0;
        end else begin
            pending_r <= pending_nxt_s;
            overrun_r <= overrun_nxt_s;
            ack_err_r <= ack_err_nxt_s;
        end
    end

    assign bus.pending     = pending_r;
    assign bus.any_pending = |pending_r;
    assign bus.clean       = clean_r;
    assign bus.overrun     = overrun_r;
    assign bus.ack_err     = ack_err_r;

endmodule

// File: tb/tb_req_debounce_latch.sv
// Directed bench for req_debounce_latch with DB_CYCLES=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_req_debounce_latch;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    req_debounce_latch_if bus_if ();

    req_debounce_latch #(
        .DB_CYCLES (4),
        .CNT_W     (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference 4-to-2 priority encoder, bit 3 highest.
    function automatic logic [1:0] enc4(input logic [3:0] v);
        if (v[3])      return 2'd3;
        else if (v[2]) return 2'd2;
        else if (v[1]) return 2'd1;
        else           return 2'd0;
    endfunction

    task automatic do_ack(input logic [1:0] idx);
        bus_if.ack     = 1'b1;
        bus_if.ack_idx = idx;
        tick(1);
        bus_if.ack     = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clk   = 1'b0;
        rst   = 1'b1;
        bus_if.raw_in      = 4'b1111;
        bus_if.ack         = 1'b0;
        bus_if.ack_idx     = 2'd0;
        bus_if.clr_overrun = 1'b0;

        // Reset with all inputs held high.
        tick(3);
        check_eq("rst_pending", bus_if.pending, 4'b0000);
        check_eq("rst_clean", bus_if.clean, 4'b0000);
        check_eq("rst_overrun", bus_if.overrun, 4'b0000);
        check_eq("rst_ack_err", bus_if.ack_err, 1'b0);
        check_eq("rst_any", bus_if.any_pending, 1'b0);
        rst = 1'b0;
        tick(5);
        check_eq("post_rst_e5_clean", bus_if.clean, 4'b0000);
        check_eq("post_rst_e5_pending", bus_if.pending, 4'b0000);
        tick(1);
        check_eq("post_rst_e6_clean", bus_if.clean, 4'b1111);
        check_eq("post_rst_e6_pending", bus_if.pending, 4'b1111);
        check_eq("post_rst_overrun", bus_if.overrun, 4'b0000);
        check_eq("post_rst_any", bus_if.any_pending, 1'b1);

        // Return to idle: release everything, then retire all requests.
        bus_if.raw_in = 4'b0000;
        tick(6);
        check_eq("release_clean", bus_if.clean, 4'b0000);
        check_eq("release_keeps_pending", bus_if.pending, 4'b1111);
        for (int i = 3; i >= 0; i--) begin
            do_ack(2'(i));
            check_eq("idle_ack_err", bus_if.ack_err, 1'b0);
        end
        check_eq("idle_pending", bus_if.pending, 4'b0000);

        // Glitch of 3 cycles on bit 2 must be rejected.
        bus_if.raw_in = 4'b0100;
        tick(3);
        bus_if.raw_in = 4'b0000;
        tick(8);
        check_eq("glitch_clean", bus_if.clean, 4'b0000);
        check_eq("glitch_pending", bus_if.pending, 4'b0000);

        // Held press on bit 2: clean and pending rise at edge 5 after the rise.
        bus_if.raw_in = 4'b0100;
        tick(5);
        check_eq("db_e4_clean", bus_if.clean, 4'b0000);
        tick(1);
        check_eq("db_e5_clean", bus_if.clean, 4'b0100);
        check_eq("db_e5_pending", bus_if.pending, 4'b0100);
        check_eq("db_e5_any", bus_if.any_pending, 1'b1);

        // Ack handshake.
        do_ack(2'd2);
        check_eq("ack2_pending", bus_if.pending, 4'b0000);
        bus_if.raw_in = 4'b1110;
        tick(6);
        check_eq("hs_pending", bus_if.pending, 4'b1010);
        do_ack(2'd3);
        check_eq("ack3_pending", bus_if.pending, 4'b0010);
        check_eq("ack3_err", bus_if.ack_err, 1'b0);
        do_ack(2'd1);
        check_eq("ack1_pending", bus_if.pending, 4'b0000);
        check_eq("ack1_any", bus_if.any_pending, 1'b0);
        do_ack(2'd0);
        check_eq("ackerr_pulse", bus_if.ack_err, 1'b1);
        check_eq("ackerr_pending", bus_if.pending, 4'b0000);
        tick(1);
        check_eq("ackerr_clear", bus_if.ack_err, 1'b0);

        // Overrun on bit 0.
        bus_if.raw_in = 4'b1111;
        tick(6);
        check_eq("ovr_first_pending", bus_if.pending, 4'b0001);
        bus_if.raw_in = 4'b1110;
        tick(6);
        check_eq("ovr_release_clean", bus_if.clean, 4'b1110);
        bus_if.raw_in = 4'b1111;
        tick(5);
        check_eq("ovr_before", bus_if.overrun, 4'b0000);
        tick(1);
        check_eq("ovr_set", bus_if.overrun, 4'b0001);
        check_eq("ovr_pending", bus_if.pending, 4'b0001);
        bus_if.clr_overrun = 1'b1;
        tick(1);
        bus_if.clr_overrun = 1'b0;
        check_eq("ovr_cleared", bus_if.overrun, 4'b0000);

        // Press on bit 1 coinciding with ack of bit 1 while it is pending.
        bus_if.raw_in = 4'b1101;
        tick(6);
        bus_if.raw_in = 4'b1111;
        tick(6);
        check_eq("sa_pre_pending", bus_if.pending, 4'b0011);
        bus_if.raw_in = 4'b1101;
        tick(6);
        bus_if.raw_in = 4'b1111;
        tick(5);
        do_ack(2'd1);
        check_eq("sa_clean", bus_if.clean, 4'b1111);
        check_eq("sa_pending", bus_if.pending, 4'b0011);
        check_eq("sa_overrun", bus_if.overrun, 4'b0000);
        check_eq("sa_ack_err", bus_if.ack_err, 1'b0);
        do_ack(2'd1);
        check_eq("sa_retire", bus_if.pending, 4'b0001);

        // Simultaneous presses on three bits.
        bus_if.raw_in = 4'b0000;
        tick(6);
        check_eq("mi_idle_clean", bus_if.clean, 4'b0000);
        do_ack(2'd0);
        check_eq("mi_idle_pending", bus_if.pending, 4'b0000);
        bus_if.raw_in = 4'b0111;
        tick(5);
        check_eq("mi_e4_pending", bus_if.pending, 4'b0000);
        tick(1);
        check_eq("mi_pending", bus_if.pending, 4'b0111);
        check_eq("mi_enc", enc4(bus_if.pending), 2'b10);
        check_eq("mi_overrun", bus_if.overrun, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/req_debounce_latch.md
Name: req_debounce_latch

Overview:
Upstream front-end for the 4-to-2 priority encoder on the FPGA board. It takes four raw, asynchronous push-button/request lines, synchronizes and debounces each one, and turns each debounced rising edge into a sticky pending request. The pending vector drives the encoder's 4-bit input directly. Downstream logic retires a request by acknowledging its encoded index; requests that are lost while already pending are flagged.

Parameters:
DB_CYCLES, 16, consecutive clk cycles the synchronized input must differ from the debounced level before that level toggles; legal range 2..65535
CNT_W, 16, debounce counter width; must satisfy 2**CNT_W >= DB_CYCLES

Ports:
clk  input  1  system clock; all logic is on the rising edge
rst  input  1  synchronous, active-high reset
raw_in  input  4  raw asynchronous request lines, active-high, bit 3 = highest priority
ack  input  1  acknowledge strobe, one cycle per acknowledge
ack_idx  input  2  index of the request being acknowledged (the encoder's out)
clr_overrun  input  1  clears all overrun flags
pending  output  4  sticky pending requests; connects to the encoder input
any_pending  output  1  OR of pending
clean  output  4  debounced level of each input
overrun  output  4  sticky flag per input: a new press arrived while that bit was already pending
ack_err  output  1  one-cycle pulse when ack targets a bit that is not pending

Behaviour:
- Reset (rst=1 at an edge):
  - sync flops, clean, all counters, pending, overrun and ack_err go to 0.
  - Reset mid-bounce discards the partial count.
  - An input held high through reset is treated as a new press once debounced after reset.
- Synchronizer, per bit: two flops, raw_in -> s1 -> s2. Only s2 is used downstream.
- Debounce, per bit i, at each edge:
  - If s2[i]==clean[i], cnt[i] is set to 0.
  - Otherwise, if cnt[i]==DB_CYCLES-1, then clean[i] is set to s2[i] and cnt[i] is set to 0.
  - Otherwise cnt[i] increments.
- Debounce latency: if raw_in[i] goes high before edge 0 and stays high, clean[i] is 1 after edge DB_CYCLES+1. Falling edges have the same latency.
- Glitches: any s2 pulse shorter than DB_CYCLES cycles never changes clean.
- Press event: press[i] is true at the edge where clean[i] goes 0 to 1. The release edge generates no event.
- Pending, per bit at each edge, evaluated in order:
  - If press[i], pending[i] is set to 1.
  - Else if ack and ack_idx==i and pending[i], pending[i] is cleared to 0.
  - Press and ack on the same bit in the same edge: set wins. Pending stays 1, no overrun is raised, and the new press is retained.
- Overrun: set on bit i when press[i] occurs, pending[i] is already 1, and no ack of bit i happens that cycle.
  - clr_overrun clears all bits.
  - A new overrun in the same cycle as clr_overrun wins: that bit stays 1.
  - Overrun does not affect pending.
- ack_err: registered one-cycle pulse when ack=1 and pending[ack_idx]=0. The pending vector is unchanged. When ack=0, ack_err=0.
- Output timing:
  - pending, clean, overrun and ack_err are all registered.
  - any_pending is combinational OR of registered pending.
  - Minimum press-to-pending latency is DB_CYCLES+2 edges from raw_in rising.
- Inputs are independent: every bit has its own synchronizer and counter, and simultaneous presses on several bits all set their pending bits in the same edge.
- No priority logic lives in this block. It presents all pending bits, and the encoder selects among them.

Test Plan (DB_CYCLES=4):
- Reset/idle: hold rst for 3 cycles with raw_in=4'b1111, then release -> all outputs 0 during reset; clean=4'b1111 and pending=4'b1111 at edge 6 after rst falls; overrun=0.
- Debounce latency and glitch: raw_in[2] high for 3 cycles then low -> clean, pending stay 0. raw_in[2] held high -> clean[2]=1 and pending=4'b0100 at edge 5 after the rise; any_pending=1.
- Ack handshake: pending=4'b1010, ack=1 with ack_idx=3 -> pending=4'b0010 next edge. ack with ack_idx=1 -> pending=0, any_pending=0. ack with ack_idx=0 -> ack_err pulses exactly 1 cycle and pending stays 0.
- Overrun: pending[0]=1; release and re-press raw_in[0] cleanly, no ack -> overrun=4'b0001 and pending unchanged. Pulse clr_overrun -> overrun=0.
- Simultaneous set and ack: time the re-press of bit 1 so its press edge coincides with ack, ack_idx=1 -> pending[1] stays 1, overrun[1]=0, ack_err=0.
- Simultaneous multi-input: raw_in goes 0 to 4'b0111 in one cycle -> pending=4'b0111 in a single edge; encoder downstream reads out=2'b10.
